// File: rtl/mem_cmd_issuer_pkg.sv
// Shared definitions for the UART memory-controller packet protocol:
// command bytes and state encodings used by both the issuer and mem_controller.
package mem_cmd_issuer_pkg;

    localparam logic [7:0] CMD_READ  = 8'h30;
    localparam logic [7:0] CMD_WRITE = 8'h31;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_SEND_ADDR = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_READ_RESP = 3'd5,
        ST_HOLD_RESP = 3'd6
    } state_e;

    // One LED per non-idle state; IDLE shows all dark.
    function automatic logic [5:0] state_onehot(input state_e s);
        logic [5:0] leds;
        leds = 6'b000000;
        case (s)
            ST_SEND_CMD:  leds = 6'b000001;
            ST_SEND_ADDR: leds = 6'b000010;
            ST_SEND_DATA: leds = 6'b000100;
            ST_WAIT_RESP: leds = 6'b001000;
            ST_READ_RESP: leds = 6'b010000;
            ST_HOLD_RESP: leds = 6'b100000;
            default:      leds = 6'b000000;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/mem_cmd_issuer.sv
// Host-side packet initiator: serializes one read/write request into the TX
// FIFO (cmd, addr[, data]) and returns the echoed read byte from the RX FIFO.
module mem_cmd_issuer
    import mem_cmd_issuer_pkg::*;
#(
    parameter int FIFO_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [FIFO_WIDTH-1:0] req_addr,
    input  logic [FIFO_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [FIFO_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    input  logic                  tx_fifo_full,
    output logic                  tx_fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] tx_dout,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] rx_din,
    output logic [5:0]            state_leds
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [FIFO_WIDTH-1:0] CMD_RD_W = FIFO_WIDTH'(CMD_READ);
    localparam logic [FIFO_WIDTH-1:0] CMD_WR_W = FIFO_WIDTH'(CMD_WRITE);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [FIFO_WIDTH-1:0] addr_q, addr_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [FIFO_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  timeout_hit;

    // An arriving byte in the last wait cycle takes precedence over the timeout.
    assign timeout_hit = TMO_EN && rx_fifo_empty && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_valid)      state_d = ST_SEND_CMD;
            ST_SEND_CMD:  if (!tx_fifo_full)  state_d = ST_SEND_ADDR;
            ST_SEND_ADDR: if (!tx_fifo_full)  state_d = write_q ? ST_SEND_DATA : ST_WAIT_RESP;
            ST_SEND_DATA: if (!tx_fifo_full)  state_d = ST_IDLE;
            ST_WAIT_RESP: begin
                if (!rx_fifo_empty)   state_d = ST_READ_RESP;
                else if (timeout_hit) state_d = ST_HOLD_RESP;
            end
            ST_READ_RESP: state_d = ST_HOLD_RESP;
            ST_HOLD_RESP: if (resp_ready)     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tmo_cnt_d   = '0;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        if (state_q == ST_IDLE && req_valid) begin
            write_d = req_write;
            addr_d  = req_addr;
            data_d  = req_data;
        end
        // Counter idles at zero, so it is already clear on entry to WAIT_RESP.
        if (state_q == ST_WAIT_RESP && rx_fifo_empty) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (timeout_hit) begin
                resp_data_d = '0;
                resp_err_d  = 1'b1;
            end
        end
        if (state_q == ST_READ_RESP) begin
            resp_data_d = rx_din;
            resp_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_cnt_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tmo_cnt_q   <= tmo_cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        resp_valid    = (state_q == ST_HOLD_RESP);
        resp_data     = resp_data_q;
        resp_err      = resp_err_q;
        tx_fifo_wr_en = 1'b0;
        tx_dout       = '0;
        rx_fifo_rd_en = 1'b0;
        state_leds    = state_onehot(state_q);
        case (state_q)
            ST_SEND_CMD: begin
                tx_fifo_wr_en = !tx_fifo_full && !rst;
                tx_dout       = write_q ? CMD_WR_W : CMD_RD_W;
            end
            ST_SEND_ADDR: begin
                tx_fifo_wr_en = !tx_fifo_full && !rst;
                tx_dout       = addr_q;
            end
            ST_SEND_DATA: begin
                tx_fifo_wr_en = !tx_fifo_full && !rst;
                tx_dout       = data_q;
            end
            ST_WAIT_RESP: rx_fifo_rd_en = !rx_fifo_empty && !rst;
            default: ;
        endcase
    end

endmodule
